// File: rtl/prog_loader_if.sv
// Byte-stream, control and memory-write bundle between the control unit, the image source and prog_loader.
interface prog_loader_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          start;
  logic          abort;
  logic [DW-1:0] byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [DW-1:0] Load_data;
  logic [AW-1:0] Load_addr;
  logic          load;
  logic          busy;
  logic          done;
  logic          cks_err;

  modport master (
    output start, abort, byte_in, byte_valid,
    input  byte_ready, Load_data, Load_addr, load, busy, done, cks_err
  );

  modport slave (
    input  start, abort, byte_in, byte_valid,
    output byte_ready, Load_data, Load_addr, load, busy, done, cks_err
  );
endinterface

// File: rtl/prog_loader.sv
// Sequential program loader: streams bytes into consecutive memory words via a one-cycle load strobe.
// Optional trailing checksum verification enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int WORDS = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  prog_loader_if.slave  bus
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_load_data;
  logic [AW-1:0] r_load_addr;
  logic          r_load;
  logic          r_busy;
  logic          r_done;
  logic          w_byte_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] r_acc;
  logic          r_cks_err;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign w_byte_ready = (r_state == RECV) || (r_state == CHECK);
`else
  assign w_byte_ready = (r_state == RECV);
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_load_addr <= '0;
      r_load      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_acc       <= '0;
      r_cks_err   <= 1'b0;
`endif
    end else if (bus.abort) begin
      // Abort beats any transfer in the same cycle; written words are left untouched.
      r_state   <= IDLE;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_cks_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state   <= RECV;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_acc     <= '0;
            r_cks_err <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (bus.byte_valid) begin
            r_load_data <= bus.byte_in;
            r_load_addr <= r_cnt;
            r_load      <= 1'b1;
            r_state     <= WRITE;
`ifdef LOADER_CHECKSUM_EN
            r_acc       <= r_acc + bus.byte_in;
`endif
          end
        end
        WRITE: begin
          r_load <= 1'b0;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= CHECK;
`else
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_state <= RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (bus.byte_valid) begin
            r_cks_err <= (bus.byte_in != r_acc);
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.Load_data  = r_load_data;
  assign bus.Load_addr  = r_load_addr;
  assign bus.load       = r_load;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
`ifdef LOADER_CHECKSUM_EN
  assign bus.cks_err    = r_cks_err;
`else
  assign bus.cks_err    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default build; checksum path when LOADER_CHECKSUM_EN is defined).
module tb_prog_loader;
  logic CLK = 1'b0;
  logic RESET;

  prog_loader_if #(.DW(8), .AW(4)) bus ();

  prog_loader #(.DW(8), .AW(4), .WORDS(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_timeout = 0;
  logic [3:0]  log_a[$];
  logic [7:0]  log_d[$];
  logic [7:0]  mem[16];
  logic [7:0]  img[16];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (bus.load === 1'b1) begin
      log_a.push_back(bus.Load_addr);
      log_d.push_back(bus.Load_data);
      mem[bus.Load_addr] <= bus.Load_data;
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic do_start();
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int bnd;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    bnd = 0;
    while (bus.byte_ready !== 1'b1 && bnd < 50) begin
      @(negedge CLK);
      bnd++;
    end
    if (bus.byte_ready !== 1'b1) begin
      n_timeout++;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic send_image(input int n, input bit rnd_gaps);
    for (int i = 0; i < n; i++)
      send_byte(img[i], rnd_gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic send_checksum(input logic [7:0] delta);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + img[i];
    send_byte(s ^ delta, 0);
`else
    s_unused(delta);
`endif
  endtask

  function automatic void s_unused(input logic [7:0] d);
    if (d === 8'hxx) $display("note: unused checksum delta");
  endfunction

  task automatic wait_done(output int unsigned at, output bit ok);
    int bnd;
    bnd = 0;
    bus.byte_valid = 1'b0;
    while (bus.done !== 1'b1 && bnd < 100) begin
      @(negedge CLK);
      bnd++;
    end
    ok = (bus.done === 1'b1);
    at = cyc;
  endtask

  function automatic int log_errors(input int n);
    int e;
    e = 0;
    if (log_a.size() != n) return 1000;
    for (int i = 0; i < n; i++)
      if (log_a[i] !== 4'(i) || log_d[i] !== img[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [22:0] got;
    RESET = 1'b1;
    #12;
    got = {bus.Load_data, bus.Load_addr, bus.load, bus.busy, bus.done, bus.cks_err, bus.byte_ready, 4'h0};
    n_checks++;
    if (got !== 23'h0) $display("FAIL reset_outputs: got %0h expected 0", got);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b0) $display("FAIL idle_no_ready: got ready=%b busy=%b expected 0/0", bus.byte_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_stream();
    int unsigned t0, td;
    bit ok;
    int e;
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    log_a.delete(); log_d.delete();
    do_start();
    t0 = cyc;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.byte_ready !== 1'b1) $display("FAIL start_busy: got busy=%b ready=%b expected 1/1", bus.busy, bus.byte_ready);
    else n_pass++;
    send_image(16, 1'b0);
    send_checksum(8'h00);
    wait_done(td, ok);
    n_checks++;
    if (!ok) $display("FAIL stream_done: got done=%b expected 1", bus.done);
    else n_pass++;
    n_checks++;
`ifdef LOADER_CHECKSUM_EN
    if (td - t0 != 33) $display("FAIL stream_latency: got %0d expected 33", td - t0);
`else
    if (td - t0 != 32) $display("FAIL stream_latency: got %0d expected 32", td - t0);
`endif
    else n_pass++;
    e = log_errors(16);
    n_checks++;
    if (e != 0) $display("FAIL stream_writes: got %0d bad entries (count %0d) expected 0", e, log_a.size());
    else n_pass++;
    e = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 8'(i)) e++;
    n_checks++;
    if (e != 0) $display("FAIL mem_readback: got %0d bad words expected 0", e);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.byte_ready !== 1'b0 || bus.cks_err !== 1'b0 || bus.Load_addr !== 4'hF || bus.Load_data !== 8'h0F)
      $display("FAIL done_state: got busy=%b ready=%b cks=%b addr=%h data=%h expected 0/0/0/f/0f",
               bus.busy, bus.byte_ready, bus.cks_err, bus.Load_addr, bus.Load_data);
    else n_pass++;
  endtask

  task automatic test_random_valid();
    int unsigned td;
    bit ok;
    int e;
    for (int i = 0; i < 16; i++) img[i] = 8'hA0 ^ 8'(i * 7);
    log_a.delete(); log_d.delete();
    do_start();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL restart_clears_done: got %b expected 0", bus.done);
    else n_pass++;
    send_image(16, 1'b1);
    send_checksum(8'h00);
    wait_done(td, ok);
    e = log_errors(16);
    n_checks++;
    if (!ok || e != 0) $display("FAIL random_valid_writes: got done=%b bad=%0d expected 1/0", bus.done, e);
    else n_pass++;
  endtask

  task automatic test_checksum();
    int unsigned td;
    bit ok;
    for (int i = 0; i < 16; i++) img[i] = 8'h11;
    for (int pass = 0; pass < 2; pass++) begin
      log_a.delete(); log_d.delete();
      do_start();
      send_image(16, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(pass == 0 ? 8'h10 : 8'h11, 0);
      wait_done(td, ok);
      n_checks++;
      if (!ok || bus.cks_err !== 1'(pass)) $display("FAIL cks_err_%0d: got done=%b cks=%b expected 1/%0d", pass, bus.done, bus.cks_err, pass);
      else n_pass++;
`else
      wait_done(td, ok);
      bus.byte_in = 8'h10; bus.byte_valid = 1'b1;
      repeat (3) @(negedge CLK);
      bus.byte_valid = 1'b0;
      n_checks++;
      if (!ok || bus.cks_err !== 1'b0 || log_a.size() != 16 || bus.done !== 1'b1)
        $display("FAIL no_cks_%0d: got done=%b cks=%b writes=%0d expected 1/0/16", pass, bus.done, bus.cks_err, log_a.size());
      else n_pass++;
`endif
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 16; i++) img[i] = 8'h50 + 8'(i);
    log_a.delete(); log_d.delete();
    do_start();
    send_image(5, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (bus.byte_ready !== 1'b1) $display("FAIL abort_setup_ready: got %b expected 1", bus.byte_ready);
    else n_pass++;
    bus.byte_in = 8'hEE; bus.byte_valid = 1'b1; bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    repeat (2) @(negedge CLK);
    bus.byte_valid = 1'b0;
    n_checks++;
    if (log_a.size() != 5 || bus.load !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.byte_ready !== 1'b0)
      $display("FAIL abort_state: got writes=%0d load=%b busy=%b done=%b ready=%b expected 5/0/0/0/0",
               log_a.size(), bus.load, bus.busy, bus.done, bus.byte_ready);
    else n_pass++;
    log_a.delete(); log_d.delete();
    do_start();
    send_byte(8'h5A, 0);
    @(negedge CLK);
    n_checks++;
    if (log_a.size() != 1 || log_a[0] !== 4'h0 || log_d[0] !== 8'h5A)
      $display("FAIL abort_restart: got writes=%0d addr=%h expected 1/0", log_a.size(), log_a.size() > 0 ? log_a[0] : 4'hx);
    else n_pass++;
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) img[i] = 8'hC0 + 8'(i);
    log_a.delete(); log_d.delete();
    do_start();
    send_image(3, 1'b0);
    bus.byte_valid = 1'b0;
    n_checks++;
    if (bus.load !== 1'b1 || bus.Load_addr !== 4'h2) $display("FAIL write_phase: got load=%b addr=%h expected 1/2", bus.load, bus.Load_addr);
    else n_pass++;
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if (bus.load !== 1'b0 || bus.busy !== 1'b0 || bus.Load_addr !== 4'h0 || bus.Load_data !== 8'h00 || bus.byte_ready !== 1'b0)
      $display("FAIL async_reset: got load=%b busy=%b addr=%h data=%h ready=%b expected 0/0/0/00/0",
               bus.load, bus.busy, bus.Load_addr, bus.Load_data, bus.byte_ready);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (log_a.size() != 2) $display("FAIL reset_no_strobe: got writes=%0d expected 2", log_a.size());
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int unsigned td;
    bit ok;
    int e;
    for (int i = 0; i < 16; i++) img[i] = 8'h3C ^ 8'(i);
    log_a.delete(); log_d.delete();
    bus.start = 1'b1;
    @(negedge CLK);
    send_image(8, 1'b0);
    bus.start = 1'b0;
    for (int i = 8; i < 16; i++) send_byte(img[i], 0);
    send_checksum(8'h00);
    wait_done(td, ok);
    e = log_errors(16);
    n_checks++;
    if (!ok || e != 0) $display("FAIL start_while_busy: got done=%b bad=%0d expected 1/0", bus.done, e);
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.byte_in = '0; bus.byte_valid = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    test_reset();
    test_stream();
    test_random_valid();
    test_checksum();
    test_abort();
    test_async_reset();
    test_start_while_busy();
    n_checks++;
    if (n_timeout != 0) $display("FAIL handshake_timeouts: got %0d expected 0", n_timeout);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
